// File: rtl/p2s_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : p2s_mc_if
// Purpose  : Bus bundle for the multi-channel parallel-to-serial converter.
//            The master side issues LOAD/FRAME/ERR_CLR and parallel data;
//            the slave side returns the serial bits and status flags.
// Revision : 1.0  initial release
// ============================================================================
interface p2s_mc_if #(
    parameter int WIDTH = 40,
    parameter int NCH   = 2
);
    logic                 FRAME;
    logic                 LOAD;
    logic [NCH*WIDTH-1:0] PDATAIN;
    logic                 ERR_CLR;
    logic [NCH-1:0]       DATAOUT;
    logic                 OutReady;
    logic                 HOLD_EMPTY;
    logic                 OVERRUN;
    logic                 UNDERRUN;
    logic                 FRAME_ERR;

    modport master (
        output FRAME, LOAD, PDATAIN, ERR_CLR,
        input  DATAOUT, OutReady, HOLD_EMPTY, OVERRUN, UNDERRUN, FRAME_ERR
    );

    modport slave (
        input  FRAME, LOAD, PDATAIN, ERR_CLR,
        output DATAOUT, OutReady, HOLD_EMPTY, OVERRUN, UNDERRUN, FRAME_ERR
    );
endinterface
`default_nettype wire

// File: rtl/p2s_mc.sv
`default_nettype none
// ============================================================================
// Module   : p2s_mc
// Purpose  : Double-buffered, multi-channel parallel-to-serial converter.
//            LOAD fills a holding buffer; FRAME moves it into the per-channel
//            shift registers, which then shift out in lockstep. Words can be
//            chained back-to-back, and overrun/underrun/framing errors are
//            reported through sticky flags.
// Revision : 1.0  initial release
// ============================================================================
module p2s_mc #(
    parameter int WIDTH     = 40,
    parameter int NCH       = 2,
    parameter int MSB_FIRST = 1
) (
    input  wire logic  SCLK,
    input  wire logic  CLR,
    p2s_mc_if.slave    bus
);
    localparam int              c_CW   = $clog2(WIDTH + 1);
    // Count value meaning "no word in flight".
    localparam logic [c_CW-1:0] c_IDLE = c_CW'(WIDTH);
    // Count value of the final bit of a word; the only in-word slot where a
    // FRAME may legally chain the next word.
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    logic [c_CW-1:0]                r_count;
    logic [NCH-1:0][WIDTH-1:0]      r_shift;
    logic [NCH-1:0][WIDTH-1:0]      r_hold;
    logic                           r_hold_valid;
    logic                           r_overrun;
    logic                           r_underrun;
    logic                           r_frame_err;

    logic [NCH-1:0][WIDTH-1:0]      w_shift_next;
    logic [NCH-1:0]                 w_dataout;
    logic                           w_idle;
    logic                           w_slot;
    logic                           w_xfer;
    logic                           w_overrun_evt;
    logic                           w_underrun_evt;
    logic                           w_frame_err_evt;

    // A FRAME is acceptable when idle or on the last bit of the current word;
    // the count never exceeds WIDTH, so anything else is strictly mid-word.
    assign w_idle          = (r_count == c_IDLE);
    assign w_slot          = w_idle || (r_count == c_LAST);
    assign w_xfer          = bus.FRAME && r_hold_valid && w_slot;
    assign w_frame_err_evt = bus.FRAME && !w_slot;
    assign w_underrun_evt  = bus.FRAME && !r_hold_valid && w_slot;
    // A LOAD that coincides with a transfer is not an overrun: the old word
    // leaves for the shifter in the same cycle the new one arrives.
    assign w_overrun_evt   = bus.LOAD && r_hold_valid && !w_xfer;

    // Per-channel shift direction and serial tap; zeros are shifted in so the
    // register drains to all-zero at the end of a word.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        if (MSB_FIRST != 0) begin : g_msb
            assign w_shift_next[g] = {r_shift[g][WIDTH-2:0], 1'b0};
            assign w_dataout[g]    = r_shift[g][WIDTH-1];
        end else begin : g_lsb
            assign w_shift_next[g] = {1'b0, r_shift[g][WIDTH-1:1]};
            assign w_dataout[g]    = r_shift[g][0];
        end
    end

    // Shifter and bit counter: load on transfer, otherwise shift while busy.
    always_ff @(posedge SCLK) begin
        if (CLR) begin
            r_count <= c_IDLE;
            r_shift <= '0;
        end else if (w_xfer) begin
            r_shift <= r_hold;
            r_count <= '0;
        end else if (!w_idle) begin
            r_shift <= w_shift_next;
            r_count <= r_count + c_CW'(1);
        end
    end

    // Holding buffer: LOAD always captures; a transfer empties it unless
    // refilled in the same cycle.
    always_ff @(posedge SCLK) begin
        if (CLR) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else if (bus.LOAD) begin
            r_hold       <= bus.PDATAIN;
            r_hold_valid <= 1'b1;
        end else if (w_xfer) begin
            r_hold_valid <= 1'b0;
        end
    end

    // Sticky status: ERR_CLR clears, but a same-cycle new event still sets.
    always_ff @(posedge SCLK) begin
        if (CLR) begin
            r_overrun   <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= (r_overrun   && !bus.ERR_CLR) || w_overrun_evt;
            r_underrun  <= (r_underrun  && !bus.ERR_CLR) || w_underrun_evt;
            r_frame_err <= (r_frame_err && !bus.ERR_CLR) || w_frame_err_evt;
        end
    end

    assign bus.DATAOUT    = w_dataout;
    assign bus.OutReady   = !w_idle;
    assign bus.HOLD_EMPTY = !r_hold_valid;
    assign bus.OVERRUN    = r_overrun;
    assign bus.UNDERRUN   = r_underrun;
    assign bus.FRAME_ERR  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_p2s_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_p2s_mc
// Purpose  : Self-checking bench for p2s_mc. Two instances (MSB-first and
//            LSB-first) share one stimulus stream; a word/bit-index reference
//            model predicts every output each cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_p2s_mc;
    localparam int W = 40;
    localparam int N = 2;

    logic SCLK = 1'b0;
    logic CLR;

    p2s_mc_if #(.WIDTH(W), .NCH(N)) bA ();
    p2s_mc_if #(.WIDTH(W), .NCH(N)) bB ();

    assign bB.FRAME   = bA.FRAME;
    assign bB.LOAD    = bA.LOAD;
    assign bB.PDATAIN = bA.PDATAIN;
    assign bB.ERR_CLR = bA.ERR_CLR;

    p2s_mc #(.WIDTH(W), .NCH(N), .MSB_FIRST(1)) dut_a (.SCLK(SCLK), .CLR(CLR), .bus(bA));
    p2s_mc #(.WIDTH(W), .NCH(N), .MSB_FIRST(0)) dut_b (.SCLK(SCLK), .CLR(CLR), .bus(bB));

    always #5 SCLK = ~SCLK;

    int n_checks = 0;
    int n_errors = 0;
    int hi_cnt   = 0;

    // Reference model: the word in flight and which bit index is on the wire.
    logic           m_busy;
    int             m_idx;
    logic [W-1:0]   m_word [N];
    logic [N*W-1:0] m_hold;
    logic           m_hv, m_ovr, m_und, m_ferr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic clr, input logic fr, input logic ld,
                              input logic [N*W-1:0] d, input logic ec);
        logic slot, xfer, e_f, e_u, e_o;
        if (clr) begin
            m_busy = 1'b0; m_idx = 0; m_hv = 1'b0;
            m_ovr = 1'b0; m_und = 1'b0; m_ferr = 1'b0;
        end else begin
            slot = !m_busy || (m_idx == W - 1);
            xfer = fr && m_hv && slot;
            e_f  = fr && !slot;
            e_u  = fr && !m_hv && slot;
            e_o  = ld && m_hv && !xfer;
            if (xfer) begin
                for (int c = 0; c < N; c++) m_word[c] = m_hold[c*W +: W];
                m_busy = 1'b1;
                m_idx  = 0;
            end else if (m_busy) begin
                if (m_idx == W - 1) m_busy = 1'b0;
                else                m_idx++;
            end
            if (ld) begin
                m_hold = d;
                m_hv   = 1'b1;
            end else if (xfer) begin
                m_hv = 1'b0;
            end
            m_ovr  = (m_ovr  && !ec) || e_o;
            m_und  = (m_und  && !ec) || e_u;
            m_ferr = (m_ferr && !ec) || e_f;
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] ea, eb;
        for (int c = 0; c < N; c++) begin
            ea[c] = m_busy ? m_word[c][W-1-m_idx] : 1'b0;
            eb[c] = m_busy ? m_word[c][m_idx]     : 1'b0;
        end
        chk("dataout_msb", 64'(bA.DATAOUT), 64'(ea));
        chk("dataout_lsb", 64'(bB.DATAOUT), 64'(eb));
        chk("outready",    64'({bB.OutReady, bA.OutReady}),     64'({2{m_busy}}));
        chk("hold_empty",  64'({bB.HOLD_EMPTY, bA.HOLD_EMPTY}), 64'({2{!m_hv}}));
        chk("flags_a", 64'({bA.OVERRUN, bA.UNDERRUN, bA.FRAME_ERR}), 64'({m_ovr, m_und, m_ferr}));
        chk("flags_b", 64'({bB.OVERRUN, bB.UNDERRUN, bB.FRAME_ERR}), 64'({m_ovr, m_und, m_ferr}));
    endtask

    task automatic step(input logic clr, input logic fr, input logic ld,
                        input logic [N*W-1:0] d, input logic ec);
        CLR = clr; bA.FRAME = fr; bA.LOAD = ld; bA.PDATAIN = d; bA.ERR_CLR = ec;
        @(posedge SCLK);
        model_step(clr, fr, ld, d, ec);
        #1;
        check_outputs();
        if (bA.OutReady === 1'b1) hi_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    // Advance until the model is about to sample bit index k (bounded).
    task automatic run_to_idx(input int k);
        for (int g = 0; g < 3 * W && !(m_busy && m_idx == k); g++) idle(1);
    endtask

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] v = '0;
        for (int i = 0; i < N * W; i += 32) v = (v << 32) | (N*W)'($urandom());
        return v;
    endfunction

    initial begin
        logic [N*W-1:0] w1, w2;
        m_busy = 1'b0; m_idx = 0; m_hv = 1'b0; m_hold = '0;
        m_ovr = 1'b0; m_und = 1'b0; m_ferr = 1'b0;
        for (int c = 0; c < N; c++) m_word[c] = '0;
        CLR = 1'b1; bA.FRAME = 1'b0; bA.LOAD = 1'b0; bA.PDATAIN = '0; bA.ERR_CLR = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("reset_state", 64'({bA.DATAOUT, bA.OutReady, bA.HOLD_EMPTY, bA.OVERRUN, bA.UNDERRUN, bA.FRAME_ERR}),
            64'({2'b00, 1'b0, 1'b1, 3'b000}));
        idle(1);

        // 1: basic word, FRAME three cycles after LOAD
        w1 = {40'h55_5555_5555, 40'h80_0000_0001};
        step(1'b0, 1'b0, 1'b1, w1, 1'b0);
        chk("t1_hold_full", 64'(bA.HOLD_EMPTY), 64'd0);
        idle(2);
        hi_cnt = 0;
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("t1_first_bits", 64'(bA.DATAOUT), 64'(2'b01));
        chk("t1_hold_empty", 64'(bA.HOLD_EMPTY), 64'd1);
        idle(45);
        chk("t1_busy_len", 64'(hi_cnt), 64'd40);

        // 2: LSB-first ordering on ch0 = 3
        w1 = {40'hA5_0F0F_1234, 40'h00_0000_0003};
        step(1'b0, 1'b0, 1'b1, w1, 1'b0);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("t2_lsb_bit0", 64'(bB.DATAOUT[0]), 64'd1);
        idle(1);
        chk("t2_lsb_bit1", 64'(bB.DATAOUT[0]), 64'd1);
        idle(1);
        chk("t2_lsb_bit2", 64'(bB.DATAOUT[0]), 64'd0);
        idle(42);

        // 3: back-to-back chaining
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b1, rand_data(), 1'b0);
        hi_cnt = 0;
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        idle(5);
        step(1'b0, 1'b0, 1'b1, rand_data(), 1'b0);
        run_to_idx(W - 1);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        idle(45);
        chk("t3_busy_len", 64'(hi_cnt), 64'd80);
        chk("t3_no_flags", 64'({bA.OVERRUN, bA.UNDERRUN, bA.FRAME_ERR}), 64'd0);

        // 4: overrun, framing error, underrun, clear
        step(1'b0, 1'b0, 1'b1, rand_data(), 1'b0);
        step(1'b0, 1'b0, 1'b1, rand_data(), 1'b0);
        chk("t4_overrun", 64'(bA.OVERRUN), 64'd1);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        run_to_idx(10);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("t4_frame_err", 64'(bA.FRAME_ERR), 64'd1);
        chk("t4_still_busy", 64'(bA.OutReady), 64'd1);
        idle(35);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("t4_underrun", 64'({bA.UNDERRUN, bA.OutReady}), 64'(2'b10));
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("t4_cleared", 64'({bA.OVERRUN, bA.UNDERRUN, bA.FRAME_ERR}), 64'd0);

        // 5: reset mid-word
        step(1'b0, 1'b0, 1'b1, rand_data(), 1'b0);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        run_to_idx(20);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("t5_abort", 64'({bA.OutReady, bA.DATAOUT, bB.DATAOUT, bA.HOLD_EMPTY}), 64'(6'b000001));
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("t5_underrun", 64'({bA.UNDERRUN, bA.OutReady}), 64'(2'b10));
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // 6: LOAD and FRAME together with a pending word
        w1 = rand_data();
        w2 = rand_data();
        step(1'b0, 1'b0, 1'b1, w1, 1'b0);
        step(1'b0, 1'b1, 1'b1, w2, 1'b0);
        chk("t6_pending", 64'({bA.HOLD_EMPTY, bA.OVERRUN, bA.OutReady}), 64'(3'b001));
        chk("t6_old_word", 64'(bA.DATAOUT), 64'({w1[2*W-1], w1[W-1]}));
        idle(42);

        // Randomised traffic, biased towards chaining at the last bit
        for (int i = 0; i < 3000; i++) begin
            logic fr, ld, ec, cl;
            fr = ($urandom_range(0, 19) == 0) || (m_busy && m_idx == W - 1 && $urandom_range(0, 1) == 0);
            ld = ($urandom_range(0, 29) == 0) || (!m_hv && $urandom_range(0, 9) == 0);
            ec = ($urandom_range(0, 49) == 0);
            cl = ($urandom_range(0, 499) == 0);
            step(cl, fr, ld, rand_data(), ec);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/p2s_mc.md
Name: p2s_mc

Overview:
- Multi-channel, double-buffered parallel-to-serial converter. It is the parametrised successor of the single-channel 40-bit serialiser in the MSDAP output path.
- A LOAD writes one word per channel into a holding buffer. A FRAME pulse then moves the buffer into the shift registers, and all NCH channels shift out in lockstep, one bit per SCLK.
- Generalised in width, channel count and bit order. Adds frame-synchronised start, back-to-back frames, and overrun/underrun/framing status.

Parameters:
- WIDTH, 40: bits per word per channel (>= 2).
- NCH, 2: number of parallel serial channels (>= 1).
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- SCLK  in  1  system clock; all logic on the rising edge.
- CLR  in  1  synchronous active-high reset.
- FRAME  in  1  frame strobe, single-cycle pulse; requests the start of a word.
- LOAD  in  1  capture PDATAIN into the holding buffer.
- PDATAIN  in  NCH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- ERR_CLR  in  1  clears the sticky status flags.
- DATAOUT  out  NCH  serial bit per channel; bit c belongs to channel c.
- OutReady  out  1  high while a word is being shifted out.
- HOLD_EMPTY  out  1  holding buffer contains no pending word.
- OVERRUN  out  1  sticky: a pending buffered word was overwritten.
- UNDERRUN  out  1  sticky: FRAME arrived with nothing to send.
- FRAME_ERR  out  1  sticky: FRAME arrived mid-word.

Behaviour:
- Reset (CLR=1 at the edge) has priority over everything. It sets:
  - shift registers = 0, bit counter = WIDTH (idle), hold_valid = 0;
  - all sticky flags = 0;
  - hence DATAOUT = 0, OutReady = 0, HOLD_EMPTY = 1.
  - A reset mid-word aborts the word immediately; no remaining bits are sent.
- Counter width is $clog2(WIDTH+1). OutReady = (count < WIDTH).
- Holding buffer:
  - LOAD with hold_valid=0: capture PDATAIN, set hold_valid=1.
  - LOAD with hold_valid=1 and no transfer in the same cycle: overwrite the buffer and set OVERRUN.
  - LOAD in the same cycle as a transfer: the transfer takes the old buffer contents, the new PDATAIN is captured, hold_valid stays 1, and OVERRUN is not set.
- Transfer condition: FRAME=1, hold_valid=1, and (idle or count == WIDTH-1).
  - On transfer: shift regs <= buffer, count <= 0, hold_valid <= 0 (unless a LOAD occurs in the same cycle).
- Start latency: if FRAME is sampled at edge k, the first bit appears on DATAOUT after edge k. Bit i is valid in cycle k+1+i, for i = 0..WIDTH-1.
- Back-to-back: FRAME at count == WIDTH-1 chains the next word with no gap cycle. OutReady stays high.
- Shifting:
  - Each cycle with count < WIDTH, count increments and every channel shifts.
  - MSB_FIRST=1: DATAOUT[c] = shift_c[WIDTH-1], shift left, fill with 0.
  - MSB_FIRST=0: DATAOUT[c] = shift_c[0], shift right, fill with 0.
- End of word: after the WIDTH-th bit with no chaining FRAME, count = WIDTH. OutReady falls and DATAOUT = 0 (the shift register is drained to zeros).
- FRAME while count < WIDTH-1: ignored; the word in progress continues unchanged; FRAME_ERR is set.
- FRAME with hold_valid=0 when a transfer would otherwise be allowed: no transfer; UNDERRUN is set; output stays idle or ends normally.
- Sticky flags:
  - ERR_CLR clears all three flags.
  - If ERR_CLR coincides with a new error event in the same cycle, the set wins.
- LOAD and FRAME are independent. A LOAD never starts transmission by itself.

Test Plan:
1. WIDTH=40, NCH=2, MSB_FIRST=1. CLR, then LOAD with ch0=40'h80_0000_0001, ch1=40'h55_5555_5555; FRAME 3 cycles later -> HOLD_EMPTY falls after LOAD and rises after FRAME. OutReady is high for exactly 40 cycles starting at FRAME+1. DATAOUT[0] = 1, then 38 zeros, then 1. DATAOUT[1] alternates 0,1,... starting with 0. Then OutReady=0 and DATAOUT=2'b00.
2. MSB_FIRST=0, ch0=40'h00_0000_0003 -> DATAOUT[0] = 1,1 then 38 zeros.
3. Back-to-back: second LOAD during word 1, FRAME at count=39 -> word 2 bit 0 immediately follows word 1 bit 39. OutReady stays high for 80 consecutive cycles. No flags set.
4. Errors:
   - Two LOADs with no FRAME between them -> OVERRUN=1, and the second word is transmitted.
   - FRAME at count=10 -> FRAME_ERR=1, and the current word completes unaltered.
   - FRAME with an empty buffer -> UNDERRUN=1 and OutReady stays 0.
   - ERR_CLR -> all flags return to 0.
5. CLR asserted at count=20 -> next cycle: OutReady=0, DATAOUT=0, HOLD_EMPTY=1. A following FRAME gives UNDERRUN=1 with no output.
6. LOAD and FRAME in the same cycle while idle and hold_valid=1 -> the old buffer contents are shifted out, the new word stays pending (HOLD_EMPTY=0), and OVERRUN=0.
